// File: rtl/adder_pipe_pkg.sv
// Shared constants and result type for the adder pipeline and its result collector.
//   ADD_WIDTH    : adder datapath width
//   ADD_LAT      : adder latency, operand capture edge to result capture edge
//   add_result_t : {cout, sum} as it leaves the adder
package adder_pipe_pkg;

  localparam int ADD_WIDTH = 32;
  localparam int ADD_LAT   = 4;

  typedef struct packed {
    logic                 cout;
    logic [ADD_WIDTH-1:0] sum;
  } add_result_t;

endpackage

// File: rtl/adder_result_collector_fifo.sv
// result_fifo: show-ahead FIFO with an occupancy count.
// Ports:
//   clk, reset  : clock (rising edge), async active-high reset
//   wr_en       : write request; wr_data is stored when there is room
//   wr_data     : entry to store
//   rd_en       : pop the head entry (ignored when empty)
//   rd_data     : head entry, zero when empty
//   count       : number of stored entries
//   ovf_err     : sticky; set when a write is dropped because the FIFO is full
module result_fifo
  import adder_pipe_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = add_result_t,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  T              wr_data,
  input  logic          rd_en,
  output T              rd_data,
  output logic [CW-1:0] count,
  output logic          ovf_err
);

  // A single-entry FIFO still needs a one-bit pointer; the explicit wrap in
  // ptr_inc keeps it pinned at zero in that case.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign pop   = rd_en && !empty;
  // A write into a full FIFO is fine when the same edge frees the head slot.
  assign push  = wr_en && (!full || pop);
  assign drop  = wr_en && full && !pop;

  // Gate the head so the output bus reads zero while nothing is stored.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
      if (drop) ovf_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/adder_result_collector.sv
// adder_result_collector: gates operand issue into a fixed-latency adder that
// has no valid signal, tracks issued operations with a LAT-deep valid shadow,
// captures the emerging results and buffers them in a show-ahead FIFO.
// Issue is credit-limited so the FIFO cannot overflow under any backpressure.
// Ports:
//   clk, reset         : clock (rising edge), async active-high reset
//   in_valid, in_ready : operand issue handshake into the adder
//   res_sum, res_cout  : adder outputs
//   out_valid, out_ready, out_sum, out_cout : result stream to the consumer
//   count              : results currently buffered
//   ovf_err            : sticky; a capture found the FIFO full
module adder_result_collector
  import adder_pipe_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH,
  parameter int LAT   = ADD_LAT,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             res_sum,
  input  logic                         res_cout,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_sum,
  output logic                         out_cout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         ovf_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(LAT + 1);
  localparam int SW = ((CW > IW) ? CW : IW) + 1;

  typedef struct packed {
    logic             cout;
    logic [WIDTH-1:0] sum;
  } result_t;

  logic [LAT-1:0] vld_sr;
  logic [IW-1:0]  inflight;
  logic [SW-1:0]  credit_used;
  logic           issue;
  logic           capture;
  result_t        wr_data;
  result_t        rd_data;

  // Credits depend only on registered state, so in_ready has no combinational
  // path from in_valid or out_ready.
  assign credit_used = SW'(count) + SW'(inflight);
  assign in_ready    = (credit_used < SW'(DEPTH));
  assign issue       = in_valid && in_ready;
  assign capture     = vld_sr[LAT-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_sr   <= '0;
      inflight <= '0;
    end else begin
      vld_sr[0] <= issue;
      for (int i = 1; i < LAT; i++) vld_sr[i] <= vld_sr[i-1];
      inflight <= inflight + IW'(issue) - IW'(capture);
    end
  end

  assign wr_data = '{cout: res_cout, sum: res_sum};

  result_fifo #(
    .DEPTH (DEPTH),
    .T     (result_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (capture),
    .wr_data (wr_data),
    .rd_en   (out_ready),
    .rd_data (rd_data),
    .count   (count),
    .ovf_err (ovf_err)
  );

  assign out_valid = (count != '0);
  assign out_sum   = rd_data.sum;
  assign out_cout  = rd_data.cout;

  credit_bound: assert property (@(posedge clk) disable iff (reset)
    credit_used <= SW'(DEPTH));

endmodule
